// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter
//   Shares one DRAM read channel between two cache fetchers (i0, i1).
//   Address side: round-robin grant into a single registered address slot.
//   Data side: an in-order tag FIFO records who asked. DRAM returns lines in
//   request order, so the FIFO head names the owner of the line now on the bus.
// Ports
//   i_clk, i_rst                  clock, async active-high reset
//   i0ra_* / i_i0ra, i1ra_* / i_i1ra   client address requests (rdy/ack)
//   i0rd_*, i1rd_*, o_rd          line delivery to clients (o_rd shared)
//   dramra_*, o_dramra            DRAM address channel (registered)
//   dramrd_*, i_dramrd            DRAM data channel (combinational pass-through)
//   o_err                         sticky: data arrived with no outstanding tag
module dram_read_arbiter #(
  parameter int GBW   = 32,
  parameter int DBW   = 16,
  parameter int CSIZE = 32,
  parameter int NOUT  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i0ra_rdy,
  output logic                 i0ra_ack,
  input  logic [GBW-1:0]       i_i0ra,
  input  logic                 i1ra_rdy,
  output logic                 i1ra_ack,
  input  logic [GBW-1:0]       i_i1ra,
  output logic                 i0rd_rdy,
  input  logic                 i0rd_ack,
  output logic                 i1rd_rdy,
  input  logic                 i1rd_ack,
  output logic [DBW*CSIZE-1:0] o_rd,
  output logic                 dramra_rdy,
  input  logic                 dramra_ack,
  output logic [GBW-1:0]       o_dramra,
  input  logic                 dramrd_rdy,
  output logic                 dramrd_ack,
  input  logic [DBW*CSIZE-1:0] i_dramrd,
  output logic                 o_err
);
  localparam int PW = $clog2(NOUT);
  localparam logic [PW:0] FULL = (PW+1)'(NOUT);

  logic [NOUT-1:0] tag_mem;   // 0 = i0, 1 = i1
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            last_grant;

  logic slot_free, can_issue, gnt0, gnt1, push, pop, head, nonempty;

  // Grant: the client that did not win last time has priority when both ask.
  // Acks are held low while reset is asserted so clients see nothing accepted.
  always_comb begin
    slot_free = !dramra_rdy || dramra_ack;
    can_issue = slot_free && (count < FULL) && !i_rst;
    gnt0      = can_issue && i0ra_rdy && (!i1ra_rdy || last_grant);
    gnt1      = can_issue && i1ra_rdy && (!i0ra_rdy || !last_grant);
    push      = gnt0 || gnt1;
  end

  assign i0ra_ack = gnt0;
  assign i1ra_ack = gnt1;

  // Data path: no storage, the FIFO head steers the handshake.
  always_comb begin
    nonempty   = (count != '0);
    head       = tag_mem[rd_ptr];
    i0rd_rdy   = dramrd_rdy && nonempty && !head;
    i1rd_rdy   = dramrd_rdy && nonempty && head;
    dramrd_ack = nonempty && (head ? i1rd_ack : i0rd_ack);
    pop        = dramrd_rdy && dramrd_ack;
  end

  assign o_rd = i_dramrd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dramra_rdy <= 1'b0;
      o_dramra   <= '0;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      o_err      <= 1'b0;
    end else begin
      if (push) begin
        dramra_rdy      <= 1'b1;
        o_dramra        <= gnt1 ? i_i1ra : i_i0ra;
        tag_mem[wr_ptr] <= gnt1;
        wr_ptr          <= wr_ptr + 1'b1;
        last_grant      <= gnt1;
      end else if (slot_free) begin
        dramra_rdy <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Fullness was judged on the pre-pop count, so push+pop at FULL is safe.
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (dramrd_rdy && !nonempty) o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// Randomized bench: clients, DRAM and a queue-based reference of the arbiter.
module tb_dram_read_arbiter;
  localparam int GBW = 32, DBW = 16, CSIZE = 32, NOUT = 4;
  localparam int LW = DBW*CSIZE;

  logic          i_clk = 1'b0, i_rst = 1'b1;
  logic          i0ra_rdy = 0, i1ra_rdy = 0, i0rd_ack = 0, i1rd_ack = 0;
  logic          dramra_ack = 0, dramrd_rdy = 0;
  logic [GBW-1:0] i_i0ra = '0, i_i1ra = '0;
  logic [LW-1:0]  i_dramrd = '0;
  logic          i0ra_ack, i1ra_ack, i0rd_rdy, i1rd_rdy, dramra_rdy, dramrd_ack, o_err;
  logic [GBW-1:0] o_dramra;
  logic [LW-1:0]  o_rd;

  always #5 i_clk = ~i_clk;

  dram_read_arbiter #(.GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .NOUT(NOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i0ra_rdy(i0ra_rdy), .i0ra_ack(i0ra_ack), .i_i0ra(i_i0ra),
    .i1ra_rdy(i1ra_rdy), .i1ra_ack(i1ra_ack), .i_i1ra(i_i1ra),
    .i0rd_rdy(i0rd_rdy), .i0rd_ack(i0rd_ack),
    .i1rd_rdy(i1rd_rdy), .i1rd_ack(i1rd_ack), .o_rd(o_rd),
    .dramra_rdy(dramra_rdy), .dramra_ack(dramra_ack), .o_dramra(o_dramra),
    .dramrd_rdy(dramrd_rdy), .dramrd_ack(dramrd_ack), .i_dramrd(i_dramrd),
    .o_err(o_err)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit roll(int p);
    return ($urandom_range(99) < p);
  endfunction

  function automatic logic [LW-1:0] line_of(logic [GBW-1:0] a);
    return {(LW/GBW){a}};
  endfunction

  // Reference state: address slot, outstanding owners, DRAM in-flight lines.
  bit             m_rdy, m_last, m_err;
  logic [GBW-1:0] m_addr;
  bit             tagq[$];
  logic [GBW-1:0] dramq[$];
  // Client / DRAM stimulus state
  bit             p0, p1, spur;
  logic [GBW-1:0] a0, a1;
  int             pr_req, pr_aack, pr_ret, pr_cack;

  task automatic model_reset();
    m_rdy = 0; m_last = 1; m_err = 0; m_addr = '0;
    tagq.delete();
  endtask

  task automatic cycle();
    bit ne, hd, free, room, e_dack, pop;
    int w;
    if (!p0 && roll(pr_req)) begin p0 = 1; a0 = $urandom; end
    if (!p1 && roll(pr_req)) begin p1 = 1; a1 = $urandom; end
    i0ra_rdy = p0; i_i0ra = a0;
    i1ra_rdy = p1; i_i1ra = a1;
    dramra_ack = roll(pr_aack);
    if (!dramrd_rdy && dramq.size() > 0 && roll(pr_ret)) dramrd_rdy = 1;
    if (spur && !dramrd_rdy && dramq.size() == 0) begin
      dramrd_rdy = 1; i_dramrd = {16{$urandom}};
    end else spur = 0;
    if (dramrd_rdy && dramq.size() > 0) i_dramrd = line_of(dramq[0]);
    i0rd_ack = roll(pr_cack);
    i1rd_ack = roll(pr_cack);
    #3;
    ne   = tagq.size() != 0;
    hd   = ne ? tagq[0] : 1'b0;
    free = !m_rdy || dramra_ack;
    room = tagq.size() < NOUT;
    w = -1;
    if (free && room) begin
      if (p0 && p1)  w = m_last ? 0 : 1;   // whoever did not win last time
      else if (p0)   w = 0;
      else if (p1)   w = 1;
    end
    e_dack = ne && (hd ? i1rd_ack : i0rd_ack);
    chk("i0ra_ack", i0ra_ack, w == 0);
    chk("i1ra_ack", i1ra_ack, w == 1);
    chk("dramra_rdy", dramra_rdy, m_rdy);
    if (m_rdy) chk("o_dramra", o_dramra, m_addr);
    chk("i0rd_rdy", i0rd_rdy, dramrd_rdy && ne && hd == 0);
    chk("i1rd_rdy", i1rd_rdy, dramrd_rdy && ne && hd == 1);
    chk("dramrd_ack", dramrd_ack, e_dack);
    chk("o_err", o_err, m_err);
    if (dramrd_rdy && ne && dramq.size() > 0) chk("o_rd", o_rd, line_of(dramq[0]));
    // advance reference
    pop = dramrd_rdy && e_dack;
    if (dramrd_rdy && !ne) m_err = 1;
    if (pop) begin void'(tagq.pop_front()); void'(dramq.pop_front()); end
    if (m_rdy && dramra_ack) dramq.push_back(m_addr);
    if (w >= 0) begin
      m_rdy = 1; m_addr = (w == 1) ? a1 : a0;
      tagq.push_back(w[0]); m_last = w[0];
      if (w == 0) p0 = 0; else p1 = 0;
    end else if (free) m_rdy = 0;
    @(posedge i_clk); #1;
    if (pop || spur) dramrd_rdy = 0;
    spur = 0;
  endtask

  task automatic run(int n, int rq, int aa, int rt, int ca);
    pr_req = rq; pr_aack = aa; pr_ret = rt; pr_cack = ca;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ":i0ra_ack"}, i0ra_ack, 0);
    chk({tag, ":i1ra_ack"}, i1ra_ack, 0);
    chk({tag, ":dramra_rdy"}, dramra_rdy, 0);
    chk({tag, ":o_dramra"}, o_dramra, 0);
    chk({tag, ":i0rd_rdy"}, i0rd_rdy, 0);
    chk({tag, ":i1rd_rdy"}, i1rd_rdy, 0);
    chk({tag, ":dramrd_ack"}, dramrd_ack, 0);
    chk({tag, ":o_err"}, o_err, 0);
  endtask

  initial begin
    p0 = 0; p1 = 0; spur = 0; a0 = '0; a1 = '0;
    model_reset();
    #2 check_reset_outputs("por");
    @(posedge i_clk); #1;
    i_rst = 0;
    run(300, 50, 80, 50, 70);    // mixed traffic
    run(200, 100, 100, 100, 100); // saturated: strict alternation
    run(30, 100, 100, 0, 100);   // no returns: fills to NOUT and stalls
    run(60, 100, 100, 100, 100); // drains, one grant per freed tag
    run(300, 60, 15, 60, 70);    // DRAM address back-pressure
    run(300, 60, 90, 80, 20);    // slow clients hold the data bus
    run(30, 0, 100, 100, 100);   // drain everything
    spur = 1;
    cycle();                     // orphan line -> sticky error
    run(100, 50, 80, 50, 70);
    // reset in the middle of traffic, with requests still asserted
    run(7, 100, 100, 0, 100);
    i_rst = 1; #1;
    check_reset_outputs("mid_rst");
    @(posedge i_clk); #1;
    i_rst = 0;
    model_reset();
    run(300, 50, 80, 60, 70);    // stale in-flight lines now arrive
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
